sampq_ctrl: RTL and testbench

//  Sequencing controller for the sample fifo RAM (1-cycle registered read, no rw check).

---
 rtl/sampq_ctrl.sv | 104 ++++++++++
 tb/tb_sampq_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sampq_ctrl.sv
// Sequencing controller for the sample FIFO RAM: pointers, overflow accounting and a
// 2-entry output stage that hides the RAM's 1-cycle registered read latency.
module sampq_ctrl #(
  parameter int ADDR_W     = 13,
  parameter int QUEUE_SIZE = 8192
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [31:0]       in_data,
  input  logic              in_avail,
  output logic [31:0]       out_data,
  output logic              out_avail,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic [15:0]       ovf_count,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic              mem_ravail,
  input  logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              mem_wavail
);

  localparam int PW = ADDR_W + 1;

  logic [PW-1:0] wptr, rptr;
  logic          inflight;
  logic [1:0]    stage_cnt, stage_nxt, stage_after_pop;
  logic [31:0]   head, skid, head_nxt, skid_nxt;
  logic          empty, full, wr_en, drop, rd_en, pop;
  logic [2:0]    occ;

  assign count = wptr - rptr;
  assign empty = (count == '0);
  assign full  = (count == PW'(QUEUE_SIZE));
  assign pop   = out_avail & out_ready;

  // Slots committed after this cycle's pop: stage entries plus a read already in flight.
  assign occ   = {1'b0, stage_cnt} + {2'b0, inflight} - {2'b0, pop};

  assign wr_en = in_avail & ~full & ~flush;
  assign drop  = in_avail & full & ~flush;
  assign rd_en = ~empty & ~flush & (occ < 3'd2);

  assign mem_wavail = wr_en;
  assign mem_waddr  = wptr[ADDR_W-1:0];
  assign mem_wdata  = in_data;
  assign mem_ravail = rd_en;
  assign mem_raddr  = rptr[ADDR_W-1:0];
  assign out_data   = head;

  assign stage_after_pop = stage_cnt - {1'b0, pop};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    head_nxt  = head;
    skid_nxt  = skid;
    stage_nxt = stage_after_pop + {1'b0, inflight};
    if (pop && stage_cnt == 2'd2) head_nxt = skid;
    if (inflight) begin
      if (stage_after_pop == 2'd0) head_nxt = mem_rdata;
      else                         skid_nxt = mem_rdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      inflight  <= 1'b0;
      stage_cnt <= 2'd0;
      head      <= '0;
      skid      <= '0;
      out_avail <= 1'b0;
      overflow  <= 1'b0;
      ovf_count <= '0;
    end else if (flush) begin
      // Stage data registers are left as-is; stage_cnt/out_avail mark them invalid.
      wptr      <= '0;
      rptr      <= '0;
      inflight  <= 1'b0;
      stage_cnt <= 2'd0;
      out_avail <= 1'b0;
      overflow  <= 1'b0;
      ovf_count <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
      inflight  <= rd_en;
      stage_cnt <= stage_nxt;
      head      <= head_nxt;
      skid      <= skid_nxt;
      out_avail <= (stage_nxt != 2'd0);
      if (drop) begin
        overflow <= 1'b1;
        if (ovf_count != 16'hFFFF) ovf_count <= ovf_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sampq_ctrl.sv
// Self-checking bench for sampq_ctrl: behavioural registered-read RAM plus an
// in-order scoreboard compared on every output pop.
module tb_sampq_ctrl;

  localparam int ADDR_W = 13;
  localparam int QS     = 8192;

  logic              clk, rst, flush;
  logic [31:0]       in_data;
  logic              in_avail;
  logic [31:0]       out_data;
  logic              out_avail;
  logic              out_ready;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic [15:0]       ovf_count;
  logic [ADDR_W-1:0] mem_raddr, mem_waddr;
  logic              mem_ravail, mem_wavail;
  logic [31:0]       mem_rdata, mem_wdata;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ram [0:QS-1];

  sampq_ctrl #(.ADDR_W(ADDR_W), .QUEUE_SIZE(QS)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_data(in_data), .in_avail(in_avail),
    .out_data(out_data), .out_avail(out_avail), .out_ready(out_ready),
    .count(count), .overflow(overflow), .ovf_count(ovf_count),
    .mem_raddr(mem_raddr), .mem_ravail(mem_ravail), .mem_rdata(mem_rdata),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wavail(mem_wavail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wavail) ram[mem_waddr] <= mem_wdata;
    if (mem_ravail) mem_rdata <= ram[mem_raddr];
  end

  // Scoreboard: every accepted pop must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && out_avail && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL out_unexpected: got %h, required no word", out_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          n_bad++;
          $display("FAIL out_order: got %h, required %h", out_data, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      step();
      k++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain: got %0d words left, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_avail = 1'b0; in_data = '0; out_ready = 1'b0;
    step(); step();
    n_cmp++; if (out_avail !== 1'b0) begin n_bad++; $display("FAIL rst_out_avail: got %b, required 0", out_avail); end
    n_cmp++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL rst_out_data: got %h, required 0", out_data); end
    n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL rst_count: got %0d, required 0", count); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rst_overflow: got %b, required 0", overflow); end
    n_cmp++; if (ovf_count !== 16'h0) begin n_bad++; $display("FAIL rst_ovf_count: got %0d, required 0", ovf_count); end
    n_cmp++; if (mem_ravail !== 1'b0) begin n_bad++; $display("FAIL rst_mem_ravail: got %b, required 0", mem_ravail); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [31:0] w [4];
    int first, last, seen;
    w[0] = 32'hA000_000A; w[1] = 32'hB000_000B; w[2] = 32'hC000_000C; w[3] = 32'hD000_000D;
    first = -1; last = -1; seen = 0;
    out_ready = 1'b1;
    in_avail  = 1'b1; in_data = w[0]; exp_q.push_back(w[0]);
    for (int k = 1; k <= 12; k++) begin
      step();
      if (out_avail) begin
        if (first < 0) first = k;
        last = k;
        seen++;
      end
      if (k < 4) begin in_data = w[k]; exp_q.push_back(w[k]); end
      else in_avail = 1'b0;
    end
    n_cmp++; if (first !== 3) begin n_bad++; $display("FAIL basic_latency: got %0d cycles, required 3", first); end
    n_cmp++; if (seen !== 4 || last - first != 3) begin n_bad++; $display("FAIL basic_contiguous: got %0d words over %0d cycles, required 4 over 4", seen, last - first + 1); end
    n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL basic_count: got %0d, required 0", count); end
    wait_drain("basic", 4);
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    in_avail  = 1'b1;
    for (int i = 0; i < QS + 2; i++) begin
      in_data = 32'h1000_0000 + i;
      exp_q.push_back(in_data);
      step();
    end
    n_cmp++; if (count !== 14'd8192) begin n_bad++; $display("FAIL ovf_full_count: got %0d, required 8192", count); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_early: got %b, required 0", overflow); end
    n_cmp++; if (out_avail !== 1'b1 || out_data !== 32'h1000_0000) begin n_bad++; $display("FAIL ovf_head: got %b/%h, required 1/10000000", out_avail, out_data); end
    in_data = 32'hBAD0_BAD0;
    #1;
    n_cmp++; if (mem_wavail !== 1'b0) begin n_bad++; $display("FAIL ovf_wavail: got %b, required 0", mem_wavail); end
    step();
    in_avail = 1'b0;
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b, required 1", overflow); end
    n_cmp++; if (ovf_count !== 16'd1) begin n_bad++; $display("FAIL ovf_count: got %0d, required 1", ovf_count); end
    n_cmp++; if (count !== 14'd8192) begin n_bad++; $display("FAIL ovf_count_after: got %0d, required 8192", count); end
  endtask

  task automatic test_drain_toggle();
    int k;
    k = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && k < 3 * QS + 100) begin
      step();
      out_ready = ~out_ready;
      k++;
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL toggle_drain: got %0d words left, required 0", exp_q.size()); end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    n_cmp++; if (out_avail !== 1'b0) begin n_bad++; $display("FAIL toggle_extra: got out_avail %b, required 0", out_avail); end
    n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL toggle_count: got %0d, required 0", count); end
  endtask

  task automatic test_flush();
    int k;
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL flush_pre_overflow: got %b, required 1", overflow); end
    out_ready = 1'b0;
    in_avail  = 1'b1;
    k = 0;
    while (!out_avail && k < 10) begin
      in_data = 32'h2000_0000 + k;
      step();
      k++;
    end
    n_cmp++; if (out_avail !== 1'b1) begin n_bad++; $display("FAIL flush_setup: got out_avail %b, required 1", out_avail); end
    flush = 1'b1; in_data = 32'hDEAD_BEEF;
    step();
    flush = 1'b0; in_avail = 1'b0;
    n_cmp++; if (out_avail !== 1'b0) begin n_bad++; $display("FAIL flush_out_avail: got %b, required 0", out_avail); end
    n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL flush_count: got %0d, required 0", count); end
    n_cmp++; if (overflow !== 1'b0 || ovf_count !== 16'h0) begin n_bad++; $display("FAIL flush_overflow: got %b/%0d, required 0/0", overflow, ovf_count); end
    step(); step();
    n_cmp++; if (out_avail !== 1'b0) begin n_bad++; $display("FAIL flush_stale: got out_avail %b, required 0", out_avail); end
    out_ready = 1'b1;
    in_avail = 1'b1; in_data = 32'h5EED_0001; exp_q.push_back(in_data);
    step();
    in_avail = 1'b0;
    wait_drain("flush", 10);
    step(); step();
    n_cmp++; if (out_avail !== 1'b0 || count !== '0) begin n_bad++; $display("FAIL flush_after: got %b/%0d, required 0/0", out_avail, count); end
  endtask

  task automatic test_sustained();
    out_ready = 1'b1;
    in_avail  = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      in_data = (i * 32'h9E37_79B1) ^ 32'h0F0F_0000;
      exp_q.push_back(in_data);
      step();
      n_cmp++;
      if (count > 14'd3) begin n_bad++; $display("FAIL sustained_count: got %0d at cycle %0d, required <=3", count, i); end
    end
    in_avail = 1'b0;
    wait_drain("sustained", 10);
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL sustained_overflow: got %b, required 0", overflow); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    in_avail  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 32'h3000_0000 + i;
      exp_q.push_back(in_data);
      step();
    end
    @(posedge clk);
    #3;
    rst = 1'b1; in_avail = 1'b0;
    exp_q.delete();
    #1;
    n_cmp++; if (out_avail !== 1'b0 || out_data !== 32'h0) begin n_bad++; $display("FAIL rstmid_out: got %b/%h, required 0/0", out_avail, out_data); end
    n_cmp++; if (count !== '0 || overflow !== 1'b0 || ovf_count !== 16'h0) begin n_bad++; $display("FAIL rstmid_state: got %0d/%b/%0d, required 0/0/0", count, overflow, ovf_count); end
    n_cmp++; if (mem_ravail !== 1'b0 || mem_wavail !== 1'b0) begin n_bad++; $display("FAIL rstmid_mem: got %b/%b, required 0/0", mem_ravail, mem_wavail); end
    step();
    rst = 1'b0;
    step();
    in_avail = 1'b1; in_data = 32'h7777_AAAA; exp_q.push_back(in_data);
    step();
    in_avail = 1'b0;
    wait_drain("rstmid", 10);
    for (int i = 0; i < 4; i++) step();
    n_cmp++; if (out_avail !== 1'b0 || count !== '0) begin n_bad++; $display("FAIL rstmid_alone: got %b/%0d, required 0/0", out_avail, count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_drain_toggle();
    test_flush();
    test_sustained();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
